booth4: RTL and testbench

BOOTH4 -- requirements
Module: booth4

---
 rtl/booth4.sv | 46 ++++
 tb/tb_booth4.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/booth4.sv
// booth4: radix-4 Booth multiplier with a registered 2N-bit product.
// Define BOOTH4_SIGNED_EN for two's complement operands; unsigned otherwise.
module booth4 #(
    parameter int N = 4
) (
    output logic [2*N-1:0] Z,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic           Clk,
    input  logic           Rst_n
);
`ifdef BOOTH4_SIGNED_EN
    localparam int ND = N/2;
    logic [2*ND:0]   bx;
    logic [2*N-1:0]  ax;
    assign bx = {B, 1'b0};
    assign ax = {{N{A[N-1]}}, A};
`else
    localparam int ND = N/2 + 1;
    logic [2*ND:0]   bx;
    logic [2*N-1:0]  ax;
    assign bx = {2'b00, B, 1'b0};
    assign ax = {{N{1'b0}}, A};
`endif
    logic [2*N-1:0] pp [ND];
    logic [2*N-1:0] sum;
    for (genvar i = 0; i < ND; i++) begin : g_pp
        logic [2:0]     t;
        logic           one, two, neg;
        logic [2*N-1:0] mag;
        assign t   = bx[2*i+2:2*i];
        assign one = t[1] ^ t[0];
        assign two = (t == 3'b100) | (t == 3'b011);
        assign neg = t[2];
        assign mag = one ? ax : two ? ax << 1 : '0;
        // negate as invert plus carry-in; digit -0 (111) still yields zero
        assign pp[i] = ((neg ? ~mag : mag) + {{(2*N-1){1'b0}}, neg}) << (2*i);
    end
    always_comb begin
        sum = '0;
        for (int k = 0; k < ND; k++) sum = sum + pp[k];
    end
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) Z <= '0;
        else Z <= sum;
endmodule

// File: tb/tb_booth4.sv
// tb_booth4: self-checking bench for booth4 against an arithmetic product model.
module tb_booth4;
    localparam int N = 4;
    logic [2*N-1:0] Z;
    logic [N-1:0]   A, B;
    logic           Clk, Rst_n;
    int n_checks = 0;
    int n_fail = 0;

    booth4 #(.N(N)) dut (.Z(Z), .A(A), .B(B), .Clk(Clk), .Rst_n(Rst_n));

    initial Clk = 0;
    always #5 Clk = ~Clk;

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
`ifdef BOOTH4_SIGNED_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        p = sa * sb;
`else
        p = int'(a) * int'(b);
`endif
        return p[2*N-1:0];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2*N-1:0] e;
        A = 4'hF; B = 4'hF; Rst_n = 1;
        #2 Rst_n = 0;
        #1;
        n_checks++;
        if (Z !== 8'h00) begin n_fail++; $display("FAIL reset_immediate Z=%h exp=00", Z); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (Z !== 8'h00) begin n_fail++; $display("FAIL reset_hold%0d Z=%h exp=00", i, Z); end
        end
        #2 Rst_n = 1;
        step();
        e = model(4'hF, 4'hF);
        n_checks++;
        if (Z !== e) begin n_fail++; $display("FAIL reset_release Z=%h exp=%h", Z, e); end
    endtask

    task automatic test_directed();
`ifdef BOOTH4_SIGNED_EN
        logic [N-1:0]   ta [3] = '{4'h8, 4'h7, 4'h8};
        logic [N-1:0]   tb [3] = '{4'h8, 4'hF, 4'h7};
        logic [2*N-1:0] tz [3] = '{8'h40, 8'hF9, 8'hC8};
`else
        logic [N-1:0]   ta [4] = '{4'hF, 4'hA, 4'h2, 4'h0};
        logic [N-1:0]   tb [4] = '{4'hF, 4'h6, 4'h3, 4'h9};
        logic [2*N-1:0] tz [4] = '{8'hE1, 8'h3C, 8'h06, 8'h00};
`endif
        foreach (ta[i]) begin
            A = ta[i]; B = tb[i];
            step();
            n_checks++;
            if (Z !== tz[i]) begin n_fail++; $display("FAIL directed%0d A=%h B=%h Z=%h exp=%h", i, ta[i], tb[i], Z, tz[i]); end
        end
    endtask

    task automatic test_exhaustive();
        logic [2*N-1:0] e;
        int bad = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                A = a[N-1:0]; B = b[N-1:0];
                step();
                e = model(A, B);
                n_checks++;
                if (Z !== e) begin
                    n_fail++; bad++;
                    if (bad <= 10) $display("FAIL exhaustive A=%h B=%h Z=%h exp=%h", A, B, Z, e);
                end
            end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]   qa [$];
        logic [N-1:0]   qb [$];
        logic [2*N-1:0] e;
        for (int i = 0; i < 40; i++) begin
            A = N'($urandom); B = N'($urandom);
            qa.push_back(A); qb.push_back(B);
            step();
            e = model(qa.pop_front(), qb.pop_front());
            n_checks++;
            if (Z !== e) begin n_fail++; $display("FAIL back_to_back%0d Z=%h exp=%h", i, Z, e); end
        end
    endtask

    task automatic test_mid_reset();
        logic [2*N-1:0] e;
        A = 4'hF; B = 4'hF;
        step();
        A = 4'h5; B = 4'h3;
        #2 Rst_n = 0;
        #1;
        n_checks++;
        if (Z !== 8'h00) begin n_fail++; $display("FAIL mid_reset_clear Z=%h exp=00", Z); end
        #1 Rst_n = 1;
        step();
        e = model(4'h5, 4'h3);
        n_checks++;
        if (Z !== e) begin n_fail++; $display("FAIL mid_reset_reload Z=%h exp=%h", Z, e); end
    endtask

    task automatic test_hold();
        logic [2*N-1:0] e0, e1;
        A = 4'h3; B = 4'h5;
        step();
        e0 = model(4'h3, 4'h5);
        for (int i = 0; i < 3; i++) begin
            #1 A = N'($urandom); B = N'($urandom);
            n_checks++;
            if (Z !== e0) begin n_fail++; $display("FAIL hold%0d Z=%h exp=%h", i, Z, e0); end
        end
        e1 = model(A, B);
        step();
        n_checks++;
        if (Z !== e1) begin n_fail++; $display("FAIL hold_update Z=%h exp=%h", Z, e1); end
    endtask

    initial begin
        Rst_n = 1; A = '0; B = '0;
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back();
        test_mid_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
